// File: rtl/fm_op_sched_if.sv
// ---------------------------------------------------------------------------
// fm_op_sched_if
// Bundles the FM operator sequencer's signals. The sequencer uses the master
// modport. The register RAMs and the EG/phase/operator datapath use the slave
// modport.
//   tick, overrun_clr       : sample strobe and overrun clear (into sequencer)
//   op_addr / op_rdata      : operator RAM read port (1-cycle read latency)
//   ch_addr / ch_rdata      : channel RAM read port (1-cycle read latency)
//   op_sel, next            : current slot and its commit strobe
//   ar, dr, sl, rr, ksr, egt: latched operator fields
//   fnum, block, kon        : latched channel fields
//   busy, sample_done       : sweep in progress / sweep finished pulse
//   overrun                 : sticky flag, set by a tick that arrives while busy
// ---------------------------------------------------------------------------
interface fm_op_sched_if;
   logic        tick;
   logic        overrun_clr;
   logic [5:0]  op_addr;
   logic [17:0] op_rdata;
   logic [4:0]  ch_addr;
   logic [13:0] ch_rdata;
   logic [5:0]  op_sel;
   logic        next;
   logic [3:0]  ar;
   logic [3:0]  dr;
   logic [3:0]  sl;
   logic [3:0]  rr;
   logic        ksr;
   logic        egt;
   logic [9:0]  fnum;
   logic [2:0]  block;
   logic        kon;
   logic        busy;
   logic        sample_done;
   logic        overrun;

   modport master (
      input  tick, overrun_clr, op_rdata, ch_rdata,
      output op_addr, ch_addr, op_sel, next,
             ar, dr, sl, rr, ksr, egt, fnum, block, kon,
             busy, sample_done, overrun
   );

   modport slave (
      output tick, overrun_clr, op_rdata, ch_rdata,
      input  op_addr, ch_addr, op_sel, next,
             ar, dr, sl, rr, ksr, egt, fnum, block, kon,
             busy, sample_done, overrun
   );
endinterface

// File: rtl/fm_op_sched.sv
// ---------------------------------------------------------------------------
// fm_op_sched
// Time-division sequencer for the FM operator datapath. Each sample tick starts
// a sweep over slots 0..NUM_OPS-1. Every slot spends four cycles in the
// sweep:
//   ADDR  - the RAM addresses for the slot are presented
//   LATCH - the RAMs answer, and the words are captured at the end of this cycle
//   EVAL  - the decoded fields are stable and the datapath computes
//   WB    - next pulses to commit the slot
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset
//   bus     : fm_op_sched_if.master (RAM read ports, decoded fields, status)
// ---------------------------------------------------------------------------
module fm_op_sched #(
   parameter int NUM_OPS = 36
) (
   input  logic          i_clk,
   input  logic          i_reset,
   fm_op_sched_if.master bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_LATCH = 3'd2;
   localparam logic [2:0] S_EVAL  = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;

   localparam logic [5:0] LAST_OP = 6'(NUM_OPS - 1);

   logic [2:0] r_state;
   logic [5:0] r_op_sel;
   logic       r_next;
   logic       r_busy;
   logic       r_done;
   logic       r_ovr;
   logic [3:0] r_ar;
   logic [3:0] r_dr;
   logic [3:0] r_sl;
   logic [3:0] r_rr;
   logic       r_ksr;
   logic       r_egt;
   logic [9:0] r_fnum;
   logic [2:0] r_block;
   logic       r_kon;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_op_sel <= '0;
         r_next   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovr    <= 1'b0;
         r_ar     <= '0;
         r_dr     <= '0;
         r_sl     <= '0;
         r_rr     <= '0;
         r_ksr    <= 1'b0;
         r_egt    <= 1'b0;
         r_fnum   <= '0;
         r_block  <= '0;
         r_kon    <= 1'b0;
      end else begin
         r_next <= 1'b0;
         r_done <= 1'b0;

         // A tick arriving while busy sets the flag. Setting takes priority over clearing.
         if (bus.tick && r_busy)
            r_ovr <= 1'b1;
         else if (bus.overrun_clr)
            r_ovr <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (bus.tick) begin
                  r_state  <= S_ADDR;
                  r_op_sel <= '0;
                  r_busy   <= 1'b1;
               end
            end
            // ---- address stage: RAM read in flight ----
            S_ADDR: r_state <= S_LATCH;
            // ---- latch stage: RAM words valid, capture the decoded fields ----
            S_LATCH: begin
               r_state <= S_EVAL;
               r_rr    <= bus.op_rdata[3:0];
               r_sl    <= bus.op_rdata[7:4];
               r_dr    <= bus.op_rdata[11:8];
               r_ar    <= bus.op_rdata[15:12];
               r_ksr   <= bus.op_rdata[16];
               r_egt   <= bus.op_rdata[17];
               r_fnum  <= bus.ch_rdata[9:0];
               r_block <= bus.ch_rdata[12:10];
               r_kon   <= bus.ch_rdata[13];
            end
            // ---- eval stage: datapath computes, commit strobe armed ----
            S_EVAL: begin
               r_state <= S_WB;
               r_next  <= 1'b1;
            end
            // ---- writeback stage: advance to the next slot or finish the sweep ----
            S_WB: begin
               if (r_op_sel == LAST_OP) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_op_sel <= r_op_sel + 6'd1;
                  r_state  <= S_ADDR;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Both RAM addresses come straight from the slot register, so they always
   // agree with op_sel. An operator pair shares a channel.
   assign bus.op_addr     = r_op_sel;
   assign bus.ch_addr     = r_op_sel[5:1];
   assign bus.op_sel      = r_op_sel;
   assign bus.next        = r_next;
   assign bus.busy        = r_busy;
   assign bus.sample_done = r_done;
   assign bus.overrun     = r_ovr;
   assign bus.ar          = r_ar;
   assign bus.dr          = r_dr;
   assign bus.sl          = r_sl;
   assign bus.rr          = r_rr;
   assign bus.ksr         = r_ksr;
   assign bus.egt         = r_egt;
   assign bus.fnum        = r_fnum;
   assign bus.block       = r_block;
   assign bus.kon         = r_kon;

endmodule

// File: doc/fm_op_sched.md
# fm_op_sched

Time-division sequencer for the FM operator datapath. On each sample tick it walks operator slots 0..NUM_OPS-1 and fetches each operator's parameter word and its channel's parameter word from the register RAMs. It presents the decoded fields and `op_sel` to the envelope/operator pipeline, then pulses `next` to commit that operator's state. It sits between the register file written by the CPU and the EG/phase/operator datapath.

## Interface
- `NUM_OPS`, default 36: operator slots per sample, 2..64. Operator `n` belongs to channel `n>>1`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  sample strobe, one cycle wide.
- `overrun_clr`  in  1  clears `overrun`.
- `op_addr`  out  6  operator RAM read address.
- `op_rdata`  in  18  operator word, valid 1 cycle after `op_addr`. Fields: [3:0] rr, [7:4] sl, [11:8] dr, [15:12] ar, [16] ksr, [17] egt.
- `ch_addr`  out  5  channel RAM read address.
- `ch_rdata`  in  14  channel word, valid 1 cycle after `ch_addr`. Fields: [9:0] fnum, [12:10] block, [13] kon.
- `op_sel`  out  6  current operator slot to the datapath.
- `next`  out  1  one-cycle commit strobe for slot `op_sel`.
- `ar`, `dr`, `sl`, `rr`  out  4 each  latched operator rates/level.
- `ksr`, `egt`  out  1 each  latched operator flags.
- `fnum`  out  10  latched channel frequency number.
- `block`  out  3  latched channel block.
- `kon`  out  1  latched channel key-on.
- `busy`  out  1  high while a sample sweep is in progress.
- `sample_done`  out  1  one-cycle pulse after the last slot commits.
- `overrun`  out  1  sticky: a tick arrived while busy.

## Operation
- States: IDLE, ADDR, LATCH, EVAL, WB. All outputs are registered.
- IDLE + `tick` -> ADDR. On entry: `op_sel`=0, `op_addr`=0, `ch_addr`=0, `busy`=1.
- ADDR -> LATCH: addresses held; the RAM responds.
- LATCH -> EVAL: `op_rdata`/`ch_rdata` are sampled at the end of LATCH into the field outputs.
- EVAL -> WB: fields and `op_sel` are stable; the datapath computes.
- WB: `next`=1 for this cycle only.
  - If `op_sel`==NUM_OPS-1: go to IDLE, `busy`=0, `sample_done`=1 on the following cycle.
  - Otherwise `op_sel`, `op_addr` += 1, `ch_addr`=(`op_sel`+1)>>1, then go to ADDR.
- `op_addr`==`op_sel` and `ch_addr`==`op_sel`>>1 at all times.
- Field outputs hold their last loaded values in IDLE; they change only at the LATCH->EVAL edge.
- `tick` while `busy`=1: ignored, `overrun` set. If set and `overrun_clr` coincide, set wins.
- `tick` in the same cycle as `sample_done` is accepted, because the state is already IDLE.
- `op_sel` stays constant from ADDR through WB of a slot, so a datapath state RAM keyed by `op_sel` has 3 cycles of read settle before the `next` write.

## Timing
- Reset (async assert, sync release): state IDLE; `op_sel`, `op_addr`, `ch_addr`, all field outputs = 0; `next`, `busy`, `sample_done`, `overrun` = 0.
- `tick` sampled high at edge T -> `busy`=1 and state ADDR from T+1.
- Slot k occupies cycles T+1+4k .. T+4+4k; `next` is high at T+4+4k.
- Last `next` at T+4·NUM_OPS; `sample_done`=1 and `busy`=0 at T+4·NUM_OPS+1.
- Minimum tick period without overrun: 4·NUM_OPS+1 cycles (145 for 36).
- Reset asserted mid-sweep aborts immediately. No `next` is issued afterward, and the partially processed slot is not committed.

## Test plan
- Reset then single `tick`, NUM_OPS=36: exactly 36 `next` pulses, spaced 4 cycles apart, `op_sel` 0..35 in order. `sample_done` 145 cycles after the tick edge; `busy` high for exactly 144 cycles.
- RAM model with op word 18'h2_5A3C at addr 7 and ch word 14'h2C00|10'h155 at addr 3: during slot 7 EVAL/WB, ar=5, dr=A, sl=3, rr=C, ksr=0, egt=1, fnum=0x155, block=3, kon=1. Values remain stable until slot 8 EVAL.
- Second `tick` 50 cycles into a sweep: `overrun`=1, sweep unaffected (still 36 `next` pulses). `overrun_clr` then drops it to 0. `tick` and `overrun_clr` in the same cycle while busy leaves `overrun`=1.
- `tick` held high in the `sample_done` cycle: new sweep starts next cycle with no overrun; back-to-back sweeps give continuous 4-cycle `next` cadence apart from the single IDLE gap.
- Reset pulsed during slot 20 LATCH: all outputs zero immediately, no `next` afterward. The next `tick` restarts from `op_sel`=0.
- NUM_OPS=2: two slots, `ch_addr`=0 for both, `sample_done` 9 cycles after the tick.
